// File: rtl/branch_fwd_d_if.sv
// Decode-stage branch/forwarding bus between the pipeline and branch_fwd_d.
// master: the pipeline side that drives instruction, operands and selects.
// slave:  the branch_fwd_d block that returns forwarded operands and status.
interface branch_fwd_d_if;
  logic [31:0] instrD;
  logic        stallD;
  logic [31:0] rf_rs;
  logic [31:0] rf_rt;
  logic [1:0]  bypass_rs_b;
  logic [1:0]  bypass_rt_b;
  logic [31:0] resultE;
  logic [31:0] wdW;
  logic [31:0] opnd_rs;
  logic [31:0] opnd_rt;
  logic        b_taken;
  logic        sel_err;

  modport master (
    output instrD, stallD, rf_rs, rf_rt, bypass_rs_b, bypass_rt_b, resultE, wdW,
    input  opnd_rs, opnd_rt, b_taken, sel_err
  );

  modport slave (
    input  instrD, stallD, rf_rs, rf_rt, bypass_rs_b, bypass_rt_b, resultE, wdW,
    output opnd_rs, opnd_rt, b_taken, sel_err
  );
endinterface

// File: rtl/branch_fwd_d.sv
// branch_fwd_d: decode-stage operand forwarding and early branch resolution.
// Holds the M-stage result register, muxes rs/rt from RF/M/W, decodes the
// branch in D, resolves it with signed compares and flags reserved selects.
// Optional macro BRANCH_FWD_STATS_EN adds saturating taken/not-taken counters.
module branch_fwd_d (
  input  logic              clk,
  input  logic              reset,
  branch_fwd_d_if.slave     bus
`ifdef BRANCH_FWD_STATS_EN
  ,
  output logic [15:0]       cnt_taken,
  output logic [15:0]       cnt_nottaken
`endif
);

  typedef enum logic [2:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_BLEZ,
    BR_BGTZ,
    BR_BLTZ,
    BR_BGEZ
  } br_kind_e;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_M   = 2'd1;
  localparam logic [1:0] SEL_W   = 2'd2;
  localparam logic [1:0] SEL_RSV = 2'd3;

  logic [31:0] res_m;
  br_kind_e    br_kind;
  logic        is_branch;
  logic        uses_rt;
  logic        sel_bad;
  logic        cond;
  logic        evaluate;

  // Source select shared by both operands; the reserved code falls back to RF.
  function automatic logic [31:0] fwd_mux(input logic [1:0] sel,
                                          input logic [31:0] rf,
                                          input logic [31:0] m,
                                          input logic [31:0] w);
    case (sel)
      SEL_M:   fwd_mux = m;
      SEL_W:   fwd_mux = w;
      default: fwd_mux = rf;
    endcase
  endfunction

  // M-stage result register: M always advances, so the D stall does not gate it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) res_m <= '0;
    else       res_m <= bus.resultE;
  end

  // Forwarded operands for the branch comparator and downstream E stage.
  assign bus.opnd_rs = fwd_mux(bus.bypass_rs_b, bus.rf_rs, res_m, bus.wdW);
  assign bus.opnd_rt = fwd_mux(bus.bypass_rt_b, bus.rf_rt, res_m, bus.wdW);

  // Branch decode from the opcode and, for REGIMM, the rt field.
  always_comb begin
    // NOTE: default assigned first so no path leaves br_kind unassigned,
    // which would otherwise infer a latch.
    br_kind = BR_NONE;
    case (bus.instrD[31:26])
      6'b000100: br_kind = BR_BEQ;
      6'b000101: br_kind = BR_BNE;
      6'b000110: br_kind = BR_BLEZ;
      6'b000111: br_kind = BR_BGTZ;
      6'b000001: begin
        if (bus.instrD[20:16] == 5'b00000)      br_kind = BR_BLTZ;
        else if (bus.instrD[20:16] == 5'b00001) br_kind = BR_BGEZ;
      end
      default: br_kind = BR_NONE;
    endcase
  end

  assign is_branch = (br_kind != BR_NONE);
  assign uses_rt   = (br_kind == BR_BEQ) || (br_kind == BR_BNE);
  assign sel_bad   = (bus.bypass_rs_b == SEL_RSV) ||
                     (uses_rt && (bus.bypass_rt_b == SEL_RSV));
  // A branch is resolved in the one cycle it sits in D unstalled.
  assign evaluate  = is_branch && !bus.stallD;

  // Signed branch condition; single-operand forms compare rs against zero.
  always_comb begin
    cond = 1'b0;
    case (br_kind)
      BR_BEQ:  cond = (bus.opnd_rs == bus.opnd_rt);
      BR_BNE:  cond = (bus.opnd_rs != bus.opnd_rt);
      BR_BLEZ: cond = ($signed(bus.opnd_rs) <= 32'sd0);
      BR_BGTZ: cond = ($signed(bus.opnd_rs) >  32'sd0);
      BR_BLTZ: cond = ($signed(bus.opnd_rs) <  32'sd0);
      BR_BGEZ: cond = ($signed(bus.opnd_rs) >= 32'sd0);
      default: cond = 1'b0;
    endcase
  end

  assign bus.b_taken = evaluate && !sel_bad && cond;

  // Sticky reserved-select flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)                    bus.sel_err <= 1'b0;
    else if (evaluate && sel_bad) bus.sel_err <= 1'b1;
  end

`ifdef BRANCH_FWD_STATS_EN
  // Saturating outcome counters, one count per resolved error-free branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_taken    <= '0;
      cnt_nottaken <= '0;
    end else if (evaluate && !sel_bad) begin
      if (cond) begin
        if (cnt_taken != 16'hFFFF) cnt_taken <= cnt_taken + 16'd1;
      end else begin
        if (cnt_nottaken != 16'hFFFF) cnt_nottaken <= cnt_nottaken + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_fwd_d.sv
// Directed testbench for branch_fwd_d; expected values are hand-computed.
// Counter checks are compiled in only when BRANCH_FWD_STATS_EN is defined.
module tb_branch_fwd_d;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  branch_fwd_d_if bus ();

`ifdef BRANCH_FWD_STATS_EN
  logic [15:0] cnt_taken;
  logic [15:0] cnt_nottaken;
  branch_fwd_d dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .cnt_taken    (cnt_taken),
    .cnt_nottaken (cnt_nottaken)
  );
`else
  branch_fwd_d dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
`endif

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] BEQ  = {6'b000100, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] BNE  = {6'b000101, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] BLEZ = {6'b000110, 5'd1, 5'd0, 16'h0010};
  localparam logic [31:0] BGTZ = {6'b000111, 5'd1, 5'd0, 16'h0010};
  localparam logic [31:0] BLTZ = {6'b000001, 5'd1, 5'b00000, 16'h0010};
  localparam logic [31:0] BGEZ = {6'b000001, 5'd1, 5'b00001, 16'h0010};
  localparam logic [31:0] RIMM = {6'b000001, 5'd1, 5'b00010, 16'h0010};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then let inputs settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic stall,
                       input logic [1:0] srs, input logic [1:0] srt,
                       input logic [31:0] rs, input logic [31:0] rt);
    bus.instrD      = instr;
    bus.stallD      = stall;
    bus.bypass_rs_b = srs;
    bus.bypass_rt_b = srt;
    bus.rf_rs       = rs;
    bus.rf_rt       = rt;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.wdW     = 32'h0;
    bus.resultE = 32'hDEAD_BEEF;
    drive(NOP, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
    step();
    step();

    // Reset state: resM cleared even though resultE was nonzero.
    drive(NOP, 1'b0, 2'd1, 2'd1, 32'h0, 32'h0);
    check("rst_resm", bus.opnd_rs, 32'h0);
    check("rst_sel_err", {31'b0, bus.sel_err}, 32'h0);
    check("rst_b_taken", {31'b0, bus.b_taken}, 32'h0);
`ifdef BRANCH_FWD_STATS_EN
    check("rst_cnt_t", {16'b0, cnt_taken}, 32'h0);
    check("rst_cnt_nt", {16'b0, cnt_nottaken}, 32'h0);
`endif
    reset = 1'b0;

    // V1: resM forwarded to rs, beq against rf_rt=5.
    bus.resultE = 32'h0000_0005;
    step();
    drive(BEQ, 1'b0, 2'd1, 2'd0, 32'h0, 32'h5);
    check("v1_opnd_rs", bus.opnd_rs, 32'h5);
    check("v1_taken", {31'b0, bus.b_taken}, 32'h1);
    bus.resultE = 32'hFFFF_FFFF;
    step();                                             // taken=1

    // V2: bne with W and M both all-ones.
    bus.wdW = 32'hFFFF_FFFF;
    drive(BNE, 1'b0, 2'd2, 2'd1, 32'h0, 32'h0);
    check("v2_opnd_rs", bus.opnd_rs, 32'hFFFF_FFFF);
    check("v2_opnd_rt", bus.opnd_rt, 32'hFFFF_FFFF);
    check("v2_taken", {31'b0, bus.b_taken}, 32'h0);
    step();                                             // nottaken=1

    // Same source on both selects: beq compares the value with itself.
    bus.wdW = 32'h1234_5678;
    drive(BEQ, 1'b0, 2'd2, 2'd2, 32'h1, 32'h2);
    check("same_src_rt", bus.opnd_rt, 32'h1234_5678);
    check("same_src_taken", {31'b0, bus.b_taken}, 32'h1);
    step();                                             // taken=2

    // V3: signed single-operand branches.
    drive(BLTZ, 1'b0, 2'd0, 2'd0, 32'h8000_0000, 32'h0);
    check("v3_bltz", {31'b0, bus.b_taken}, 32'h1);
    step();                                             // taken=3
    drive(BGEZ, 1'b0, 2'd0, 2'd0, 32'h8000_0000, 32'h0);
    check("v3_bgez", {31'b0, bus.b_taken}, 32'h0);
    step();                                             // nottaken=2
    drive(BLEZ, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
    check("v3_blez0", {31'b0, bus.b_taken}, 32'h1);
    step();                                             // taken=4
    drive(BGTZ, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
    check("v3_bgtz0", {31'b0, bus.b_taken}, 32'h0);
    step();                                             // nottaken=3
    drive(BGTZ, 1'b0, 2'd0, 2'd0, 32'h7FFF_FFFF, 32'h0);
    check("v3_bgtz_max", {31'b0, bus.b_taken}, 32'h1);
    step();                                             // taken=5
    drive(RIMM, 1'b0, 2'd0, 2'd0, 32'h8000_0000, 32'h0);
    check("regimm_nonbr", {31'b0, bus.b_taken}, 32'h0);
    step();                                             // no count
    // Single-operand branch ignores a reserved rt select.
    drive(BLTZ, 1'b0, 2'd0, 2'd3, 32'hFFFF_FFFF, 32'h0);
    check("bltz_rt_rsv", {31'b0, bus.b_taken}, 32'h1);
    step();                                             // taken=6
    check("bltz_rt_rsv_err", {31'b0, bus.sel_err}, 32'h0);

    // V4: stalled beq resolves only in the release cycle; resM keeps loading.
    for (int i = 0; i < 3; i++) begin
      bus.resultE = 32'hA000_0000 + i;
      drive(BEQ, 1'b1, 2'd0, 2'd0, 32'h7, 32'h7);
      check("v4_stalled", {31'b0, bus.b_taken}, 32'h0);
      step();
    end
    drive(BEQ, 1'b0, 2'd0, 2'd0, 32'h7, 32'h7);
    check("v4_release", {31'b0, bus.b_taken}, 32'h1);
    check("v4_resm_loads", bus.opnd_rt, 32'h7);
    drive(BEQ, 1'b0, 2'd1, 2'd0, 32'h7, 32'hA000_0002);
    check("v4_resm_val", bus.opnd_rs, 32'hA000_0002);
    step();                                             // taken=7
`ifdef BRANCH_FWD_STATS_EN
    check("v4_cnt_t", {16'b0, cnt_taken}, 32'd7);
    check("v4_cnt_nt", {16'b0, cnt_nottaken}, 32'd3);
`endif

    // V5: reserved rt select on beq.
    drive(BEQ, 1'b0, 2'd0, 2'd3, 32'h9, 32'h9);
    check("v5_taken", {31'b0, bus.b_taken}, 32'h0);
    check("v5_err_before", {31'b0, bus.sel_err}, 32'h0);
    step();
    check("v5_err_set", {31'b0, bus.sel_err}, 32'h1);
    drive(NOP, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
    step();
    check("v5_err_held", {31'b0, bus.sel_err}, 32'h1);
`ifdef BRANCH_FWD_STATS_EN
    check("v5_cnt_t", {16'b0, cnt_taken}, 32'd7);
`endif
    // Reset during a stall.
    bus.resultE = 32'h0000_0055;
    drive(BEQ, 1'b1, 2'd0, 2'd0, 32'h3, 32'h3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(BEQ, 1'b1, 2'd1, 2'd0, 32'h3, 32'h3);
    check("v5_rst_err", {31'b0, bus.sel_err}, 32'h0);
    check("v5_rst_resm", bus.opnd_rs, 32'h0);
`ifdef BRANCH_FWD_STATS_EN
    check("v5_rst_cnt", {16'b0, cnt_taken}, 32'h0);
`endif
    drive(BEQ, 1'b0, 2'd0, 2'd0, 32'h3, 32'h3);
    check("v5_fresh_taken", {31'b0, bus.b_taken}, 32'h1);
    step();                                             // taken=1

`ifdef BRANCH_FWD_STATS_EN
    check("v5_fresh_cnt", {16'b0, cnt_taken}, 32'd1);
    // V6: saturation of the taken counter.
    for (int i = 0; i < 65533; i++) step();            // taken=65534
    check("v6_cnt_fffe", {16'b0, cnt_taken}, 32'h0000_FFFE);
    for (int i = 0; i < 7; i++) step();
    check("v6_cnt_sat", {16'b0, cnt_taken}, 32'h0000_FFFF);
    check("v6_cnt_nt", {16'b0, cnt_nottaken}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
